// File: rtl/sevseg_scan_if.sv
// Display-side bundle for the stopwatch seven-segment scanner: time fields and
// mode controls in, active-low segment/anode/decimal-point drive out.
interface sevseg_scan_if;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic       adjust;
    logic       selection;
    logic [0:6] seg;
    logic [3:0] an;
    logic       dp;

    modport master (
        output minutes,
        output seconds,
        output adjust,
        output selection,
        input  seg,
        input  an,
        input  dp
    );

    modport slave (
        input  minutes,
        input  seconds,
        input  adjust,
        input  selection,
        output seg,
        output an,
        output dp
    );
endinterface

// File: rtl/sevseg_scan.sv
// Four-digit multiplexed common-anode driver: snapshots mm:ss once per frame,
// converts to BCD and scans one digit per SCAN_DIV cycles, blinking a field in adjust mode.
module sevseg_scan #(
    parameter int SCAN_DIV  = 100000,
    parameter int BLINK_DIV = 25000000
) (
    input  logic         clk,
    input  logic         rst_n,
    sevseg_scan_if.slave disp
);

    localparam int SCAN_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    localparam logic [0:6] SEG_DASH  = 7'b1111110;
    localparam logic [0:6] SEG_BLANK = 7'b1111111;

    function automatic logic [7:0] bin_to_bcd(input logic [5:0] v);
        logic [5:0] rem;
        logic [3:0] tens;
        rem  = v;
        tens = '0;
        for (int i = 0; i < 6; i++) begin
            if (rem >= 6'd10) begin
                rem  = rem - 6'd10;
                tens = tens + 4'd1;
            end
        end
        return {tens, 4'(rem)};
    endfunction

    function automatic logic [0:6] seg_decode(input logic [3:0] d);
        logic [0:6] s;
        case (d)
            4'd0:    s = 7'b0000001;
            4'd1:    s = 7'b1001111;
            4'd2:    s = 7'b0010010;
            4'd3:    s = 7'b0000110;
            4'd4:    s = 7'b1001100;
            4'd5:    s = 7'b0100100;
            4'd6:    s = 7'b0100000;
            4'd7:    s = 7'b0001111;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0000100;
            default: s = SEG_DASH;
        endcase
        return s;
    endfunction

    logic [SCAN_W-1:0]  scan_cnt_q, scan_cnt_d;
    logic [1:0]         idx_q, idx_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               blink_ph_q, blink_ph_d;
    logic [5:0]         min_q, min_d;
    logic [5:0]         sec_q, sec_d;
    logic [3:0]         an_q, an_d;
    logic [0:6]         seg_q, seg_d;
    logic               dp_q, dp_d;

    logic               scan_tick;
    logic               frame_wrap;
    logic [7:0]         min_bcd, sec_bcd;
    logic [3:0]         digit;
    logic               field_bad;
    logic               blank;

    always_comb begin
        scan_tick  = (scan_cnt_q == SCAN_LAST);
        frame_wrap = scan_tick && (idx_q == 2'd3);
        scan_cnt_d = scan_tick ? '0 : scan_cnt_q + SCAN_W'(1);
        idx_d      = scan_tick ? idx_q + 2'd1 : idx_q;
        // Capture only at frame wrap so all four digits come from one sample.
        min_d      = frame_wrap ? disp.minutes : min_q;
        sec_d      = frame_wrap ? disp.seconds : sec_q;
    end

    always_comb begin
        blink_cnt_d = '0;
        blink_ph_d  = 1'b0;
        if (disp.adjust) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d = '0;
                blink_ph_d  = ~blink_ph_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BLINK_W'(1);
                blink_ph_d  = blink_ph_q;
            end
        end
    end

    always_comb begin
        min_bcd = bin_to_bcd(min_q);
        sec_bcd = bin_to_bcd(sec_q);
        digit   = '0;
        case (idx_q)
            2'd0: digit = sec_bcd[3:0];
            2'd1: digit = sec_bcd[7:4];
            2'd2: digit = min_bcd[3:0];
            2'd3: digit = min_bcd[7:4];
            default: digit = '0;
        endcase
        // idx[1] distinguishes the minutes pair (2,3) from the seconds pair (0,1).
        field_bad = idx_q[1] ? (min_q >= 6'd60) : (sec_q >= 6'd60);
        blank     = disp.adjust && blink_ph_q &&
                    (disp.selection ? ~idx_q[1] : idx_q[1]);

        an_d  = blank ? 4'b1111 : ~(4'b0001 << idx_q);
        seg_d = blank ? SEG_BLANK : (field_bad ? SEG_DASH : seg_decode(digit));
        dp_d  = blank ? 1'b1 : (idx_q != 2'd2);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt_q  <= '0;
            idx_q       <= '0;
            blink_cnt_q <= '0;
            blink_ph_q  <= 1'b0;
            min_q       <= '0;
            sec_q       <= '0;
            an_q        <= 4'b1111;
            seg_q       <= SEG_BLANK;
            dp_q        <= 1'b1;
        end else begin
            scan_cnt_q  <= scan_cnt_d;
            idx_q       <= idx_d;
            blink_cnt_q <= blink_cnt_d;
            blink_ph_q  <= blink_ph_d;
            min_q       <= min_d;
            sec_q       <= sec_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
        end
    end

    assign disp.an  = an_q;
    assign disp.seg = seg_q;
    assign disp.dp  = dp_q;

endmodule

// File: doc/sevseg_scan.md
# sevseg_scan

Four-digit multiplexed seven-segment driver for the stopwatch. Sits directly downstream of the minute/second counter: it takes binary `minutes`/`seconds` (0–59), converts each field to two BCD digits and scans them onto the board's common-anode display. In adjust mode it blinks the selected field. All logic runs on the 100 MHz board clock using internal enable ticks, with no derived clocks.

## Interface
- `SCAN_DIV`, default 100000: clk cycles per digit slot, giving a 1 kHz digit rate and 250 Hz refresh.
- `BLINK_DIV`, default 25000000: clk cycles per blink half-period, giving a 2 Hz toggle.
- `clk`  in  1  board clock, 100 MHz; the only clock in the block.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `minutes`  in  6  minutes field, binary, synchronous to `clk`.
- `seconds`  in  6  seconds field, binary, synchronous to `clk`.
- `adjust`  in  1  1 = adjust mode; the selected field blinks.
- `selection`  in  1  0 = minutes selected, 1 = seconds selected.
- `seg`  out  [0:6]  segment cathodes, active-low; `seg[0]` is a through `seg[6]` is g.
- `an`  out  4  digit anodes, active-low, one-hot-low when a digit is lit.
- `dp`  out  1  decimal point, active-low; used as the min:sec separator.

## Operation
- **Scan prescaler**
  - `scan_cnt` counts 0..`SCAN_DIV`-1 and wraps.
  - `scan_tick` is asserted in the cycle where `scan_cnt` = `SCAN_DIV`-1.
- **Digit index**
  - `idx` is 2 bits and increments on `scan_tick`, wrapping 3→0.
  - `idx` 0 → `an[0]`, seconds ones.
  - `idx` 1 → `an[1]`, seconds tens.
  - `idx` 2 → `an[2]`, minutes ones.
  - `idx` 3 → `an[3]`, minutes tens.
- **Frame snapshot**
  - On the `scan_tick` edge where `idx` = 3 (frame wrap), `min_q`/`sec_q` capture `minutes`/`seconds`.
  - The display never tears inside a frame.
- **BCD conversion**
  - Per field: tens = v/10 and ones = v mod 10, via a compare/subtract chain. No divider primitives.
  - Field value 60–63 is out of range: both digits of that field show a dash (g only, `seg` = 1111110).
- **Decoder**
  - 0–9 map to the standard patterns, active-low.
  - Examples: 0 → 0000001, 1 → 1001111, 8 → 0000000.
- **Blink**
  - `blink_cnt` counts 0..`BLINK_DIV`-1; `blink_ph` toggles at the terminal count.
  - While `adjust` = 0, `blink_cnt` and `blink_ph` are held at 0.
- **Blanking**
  - If `adjust` = 1, `blink_ph` = 1, and the current `idx` belongs to the selected field (`selection` = 0 → idx 2,3; `selection` = 1 → idx 0,1), then `an` = 1111 and `seg` = 1111111 for that slot.
  - The other field is unaffected.
- **Separator:** `dp` = 0 when `idx` = 2, otherwise 1. `dp` is also blanked with its slot.
- **Live inputs:** `adjust` and `selection` are used live, not snapshotted. They are same-domain inputs and are not synchronized.

## Timing
- **Reset**
  - Asynchronous on `rst_n` = 0.
  - Internal state: `scan_cnt` = 0, `idx` = 0, `blink_cnt` = 0, `blink_ph` = 0, `min_q` = 0, `sec_q` = 0.
  - Outputs: `an` = 1111, `seg` = 1111111, `dp` = 1.
- **Release:** outputs are registered. The first clk edge after `rst_n` rises drives `idx` 0 from the snapshot (all zeros): `an` = 1110, `seg` = 0000001.
- **Output latency:** `an`/`seg`/`dp` reflect a new `idx` exactly 1 cycle after `idx` changes. Each digit is lit for `SCAN_DIV` cycles.
- **Snapshot latency**
  - An input change is displayed starting at the slot after the next frame wrap.
  - Worst case is 4·`SCAN_DIV`+1 cycles.
- **Adjust assertion:** the blink restarts in the lit phase; the first blanking occurs `BLINK_DIV` cycles after `adjust` rises. Deassertion un-blanks on the next output update (1 cycle).
- **Selection change during blanking:** takes effect on the next output register update, with no wait for a frame boundary.
- **Reset mid-frame:** all counters clear immediately. The snapshot returns to 0 and the display shows 00:00 until the first frame wrap after release.
- **No glitch:** `an` never has more than one bit low in any cycle.

## Test plan
Bench uses `SCAN_DIV` = 4 and `BLINK_DIV` = 8.
- **Reset:** hold `rst_n` = 0 with `minutes` = 12, `seconds` = 34 → `an` = 1111, `seg` = 1111111, `dp` = 1. One cycle after release → `an` = 1110, `seg` = 0000001, and 00:00 persists until the first wrap.
- **Scan sequence:** `minutes` = 12, `seconds` = 34 after one full frame → successive slots show `an` 1110/1101/1011/0111 with digits 4, 3, 2, 1. Each slot lasts 4 cycles; `dp` = 0 only while `an` = 1011.
- **Snapshot coherence:** change `seconds` 34→35 while `idx` = 1 → the remaining slots of that frame still show 34; the next frame shows 5 at `an[0]`.
- **Out-of-range field:** `minutes` = 61 → `an[3]` and `an[2]` slots show `seg` = 1111110; the seconds digits are normal.
- **Blink:** `adjust` = 1, `selection` = 1 → seconds slots are lit for 8 cycles, then blank (`an` = 1111) for 8 cycles, repeating; the minutes slots are never blank. Set `adjust` = 0 while blank → the next update is lit.
- **Async reset mid-frame:** assert `rst_n` = 0 at `idx` = 2 between clock edges → outputs go to 1111/1111111/1 immediately, without waiting for a clk edge.
